// File: rtl/score_readout.sv
// rtl/score_readout.sv - arbitrated score RAM readout with BCD display digits
// Optional leader scan over all player IDs is compiled in by defining LEADER_SCAN_EN.
module score_readout #(
    parameter int NUM_PLAYERS = 32,
    parameter int MAX_DISP    = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       read_request,
    input  logic [4:0] playerID,
    input  logic       scan_request,
    output logic       ram_req,
    input  logic       ram_gnt,
    output logic [4:0] RAMaddr,
    input  logic [6:0] fromRAM,
    output logic [6:0] score_out,
    output logic [3:0] D10,
    output logic [3:0] D1,
    output logic       valid,
    output logic       addr_err,
    output logic       busy,
    output logic       scan_done,
    output logic [4:0] top_player,
    output logic [6:0] top_score
);
    localparam logic [5:0] NP    = 6'(NUM_PLAYERS);
    localparam logic [6:0] MAX_V = 7'(MAX_DISP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_WT,
        S_DN
`ifdef LEADER_SCAN_EN
        , S_SCAN
`endif
    } state_t;

    state_t     state_q;
    logic [4:0] id_q;
    logic [4:0] addr_q;
    logic       ram_req_q;
    logic       valid_q;
    logic       addr_err_q;
    logic [6:0] score_q;
    logic [3:0] d10_q;
    logic [3:0] d1_q;
    logic [6:0] clamp_d;
    logic [3:0] tens_d;
    logic [3:0] ones_d;

    // Digits are derived from the incoming RAM word so they land on the same edge as score_out.
    always_comb begin
        clamp_d = (fromRAM > MAX_V) ? MAX_V : fromRAM;
        tens_d  = 4'(clamp_d / 7'd10);
        ones_d  = 4'(clamp_d % 7'd10);
    end

`ifdef LEADER_SCAN_EN
    logic       scan_q;
    logic [5:0] cnt_q;
    logic [6:0] best_score_q;
    logic [6:0] best_score_d;
    logic [4:0] best_id_q;
    logic [4:0] best_id_d;
    logic [6:0] top_score_q;
    logic [4:0] top_player_q;
    logic       scan_done_q;

    // fromRAM holds the word of address cnt_q-1 while cnt_q is being addressed.
    always_comb begin
        best_score_d = best_score_q;
        best_id_d    = best_id_q;
        if (cnt_q != 6'd0 && fromRAM > best_score_q) begin
            best_score_d = fromRAM;
            best_id_d    = 5'(cnt_q - 6'd1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            id_q       <= 5'd0;
            addr_q     <= 5'd0;
            ram_req_q  <= 1'b0;
            valid_q    <= 1'b0;
            addr_err_q <= 1'b0;
            score_q    <= 7'd0;
            d10_q      <= 4'd0;
            d1_q       <= 4'd0;
`ifdef LEADER_SCAN_EN
            scan_q       <= 1'b0;
            cnt_q        <= 6'd0;
            best_score_q <= 7'd0;
            best_id_q    <= 5'd0;
            top_score_q  <= 7'd0;
            top_player_q <= 5'd0;
            scan_done_q  <= 1'b0;
`endif
        end else begin
            valid_q    <= 1'b0;
            addr_err_q <= 1'b0;
`ifdef LEADER_SCAN_EN
            scan_done_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (read_request) begin
                        if ({1'b0, playerID} < NP) begin
                            id_q      <= playerID;
                            ram_req_q <= 1'b1;
                            state_q   <= S_REQ;
`ifdef LEADER_SCAN_EN
                            scan_q    <= 1'b0;
`endif
                        end else begin
                            addr_err_q <= 1'b1;
                        end
                    end
`ifdef LEADER_SCAN_EN
                    else if (scan_request) begin
                        scan_q    <= 1'b1;
                        ram_req_q <= 1'b1;
                        state_q   <= S_REQ;
                    end
`endif
                end
                S_REQ: begin
                    if (ram_gnt) begin
`ifdef LEADER_SCAN_EN
                        if (scan_q) begin
                            addr_q       <= 5'd0;
                            cnt_q        <= 6'd0;
                            best_score_q <= 7'd0;
                            best_id_q    <= 5'd0;
                            state_q      <= S_SCAN;
                        end else begin
                            addr_q  <= id_q;
                            state_q <= S_RD;
                        end
`else
                        addr_q  <= id_q;
                        state_q <= S_RD;
`endif
                    end
                end
                S_RD: begin
                    state_q <= ram_gnt ? S_WT : S_REQ;
                end
                S_WT: begin
                    if (!ram_gnt) begin
                        state_q <= S_REQ;
                    end else begin
                        score_q   <= fromRAM;
                        d10_q     <= tens_d;
                        d1_q      <= ones_d;
                        valid_q   <= 1'b1;
                        ram_req_q <= 1'b0;
                        state_q   <= S_DN;
                    end
                end
                S_DN: begin
                    state_q <= S_IDLE;
                end
`ifdef LEADER_SCAN_EN
                S_SCAN: begin
                    if (!ram_gnt) begin
                        state_q <= S_REQ;
                    end else begin
                        best_score_q <= best_score_d;
                        best_id_q    <= best_id_d;
                        if (cnt_q == NP) begin
                            top_score_q  <= best_score_d;
                            top_player_q <= best_id_d;
                            scan_done_q  <= 1'b1;
                            ram_req_q    <= 1'b0;
                            state_q      <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                            if (cnt_q < NP - 6'd1) begin
                                addr_q <= cnt_q[4:0] + 5'd1;
                            end
                        end
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ram_req   = ram_req_q;
    assign RAMaddr   = addr_q;
    assign score_out = score_q;
    assign D10       = d10_q;
    assign D1        = d1_q;
    assign valid     = valid_q;
    assign addr_err  = addr_err_q;
    assign busy      = (state_q != S_IDLE);

`ifdef LEADER_SCAN_EN
    assign scan_done  = scan_done_q;
    assign top_player = top_player_q;
    assign top_score  = top_score_q;
`else
    logic unused_scan_request;
    assign unused_scan_request = scan_request;
    assign scan_done  = 1'b0;
    assign top_player = 5'd0;
    assign top_score  = 7'd0;
`endif
endmodule

// File: tb/tb_score_readout.sv
// tb/tb_score_readout.sv - directed self-checking bench for score_readout
// Scan scenarios follow LEADER_SCAN_EN as used for the design build.
module tb_score_readout;
    localparam int NP = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       read_request;
    logic [4:0] playerID;
    logic       scan_request;
    logic       ram_req;
    logic       ram_gnt;
    logic [4:0] RAMaddr;
    logic [6:0] fromRAM = 7'd0;
    logic [6:0] score_out;
    logic [3:0] D10;
    logic [3:0] D1;
    logic       valid;
    logic       addr_err;
    logic       busy;
    logic       scan_done;
    logic [4:0] top_player;
    logic [6:0] top_score;

    logic [6:0] ram [32];
    int checks = 0;
    int errors = 0;

    score_readout #(.NUM_PLAYERS(NP), .MAX_DISP(99)) dut (
        .clk(clk), .rst(rst), .read_request(read_request), .playerID(playerID),
        .scan_request(scan_request), .ram_req(ram_req), .ram_gnt(ram_gnt),
        .RAMaddr(RAMaddr), .fromRAM(fromRAM), .score_out(score_out), .D10(D10),
        .D1(D1), .valid(valid), .addr_err(addr_err), .busy(busy),
        .scan_done(scan_done), .top_player(top_player), .top_score(top_score)
    );

    always #5 clk = ~clk;

    always @(posedge clk) fromRAM <= ram[RAMaddr];

    task automatic issue_read(input logic [4:0] id, input logic init_gnt, input int off_k,
                              input int on_k, output int lat, output bit req_held);
        @(negedge clk);
        ram_gnt = init_gnt;
        read_request = 1'b1;
        playerID = id;
        @(negedge clk);
        read_request = 1'b0;
        lat = -1;
        req_held = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == off_k) ram_gnt = 1'b0;
            if (k == on_k) ram_gnt = 1'b1;
            if (valid === 1'b1) begin
                lat = k;
                break;
            end
            if (ram_req !== 1'b1) req_held = 1'b0;
            @(negedge clk);
        end
        ram_gnt = 1'b1;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (ram_req !== 1'b0) begin errors++; $display("FAIL reset_ram_req got %0d want 0", ram_req); end
        checks++; if (RAMaddr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", RAMaddr); end
        checks++; if (score_out !== 7'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score_out); end
        checks++; if ({D10, D1} !== 8'd0) begin errors++; $display("FAIL reset_digits got %0d%0d want 00", D10, D1); end
        checks++; if ({valid, addr_err, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {valid, addr_err, busy}); end
        checks++; if ({scan_done, top_player, top_score} !== 13'd0) begin errors++; $display("FAIL reset_scan got %0d/%0d/%0d want 0", scan_done, top_player, top_score); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_read_basic;
        int lat;
        bit held;
        ram[1] = 7'd15;
        issue_read(5'd1, 1'b1, 0, 0, lat, held);
        checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d want 4", lat); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL basic_req_held got %0d want 1", held); end
        checks++; if (score_out !== 7'd15) begin errors++; $display("FAIL basic_score got %0d want 15", score_out); end
        checks++; if (D10 !== 4'd1 || D1 !== 4'd5) begin errors++; $display("FAIL basic_digits got %0d%0d want 15", D10, D1); end
        checks++; if (ram_req !== 1'b0) begin errors++; $display("FAIL basic_dn_req got %0d want 0", ram_req); end
        @(negedge clk);
        checks++; if ({valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_after got %b want 00", {valid, busy}); end
    endtask

    task automatic test_digits;
        logic [4:0] ids   [6] = '{5'd2, 5'd4, 5'd6, 5'd29, 5'd7, 5'd0};
        logic [6:0] data  [6] = '{7'd70, 7'd120, 7'd100, 7'd99, 7'd45, 7'd0};
        logic [3:0] tens  [6] = '{4'd7, 4'd9, 4'd9, 4'd9, 4'd4, 4'd0};
        logic [3:0] ones  [6] = '{4'd0, 4'd9, 4'd9, 4'd9, 4'd5, 4'd0};
        int lat;
        bit held;
        for (int i = 0; i < 6; i++) begin
            ram[ids[i]] = data[i];
            issue_read(ids[i], 1'b1, 0, 0, lat, held);
            checks++; if (lat !== 4) begin errors++; $display("FAIL digits_latency id %0d got %0d want 4", ids[i], lat); end
            checks++; if (score_out !== data[i]) begin errors++; $display("FAIL digits_score id %0d got %0d want %0d", ids[i], score_out, data[i]); end
            checks++; if (D10 !== tens[i] || D1 !== ones[i]) begin errors++; $display("FAIL digits_bcd id %0d got %0d%0d want %0d%0d", ids[i], D10, D1, tens[i], ones[i]); end
        end
    endtask

    task automatic test_addr_err;
        logic [4:0] bad [2] = '{5'd30, 5'd31};
        bit quiet;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            read_request = 1'b1;
            playerID = bad[i];
            @(negedge clk);
            read_request = 1'b0;
            checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL addr_err_pulse id %0d got %0d want 1", bad[i], addr_err); end
            quiet = (ram_req === 1'b0) && (busy === 1'b0) && (valid === 1'b0);
            @(negedge clk);
            checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL addr_err_width id %0d got %0d want 0", bad[i], addr_err); end
            for (int k = 0; k < 4; k++) begin
                if (ram_req !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
                @(negedge clk);
            end
            checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL addr_err_quiet id %0d got %0d want 1", bad[i], quiet); end
        end
    endtask

    task automatic test_gnt_stall;
        int lat;
        bit held;
        ram[1] = 7'd15;
        issue_read(5'd1, 1'b0, 0, 6, lat, held);
        checks++; if (lat !== 9) begin errors++; $display("FAIL stall_latency got %0d want 9", lat); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL stall_req_held got %0d want 1", held); end
        checks++; if (score_out !== 7'd15) begin errors++; $display("FAIL stall_score got %0d want 15", score_out); end
    endtask

    task automatic test_gnt_drop;
        int lat;
        bit held;
        ram[3] = 7'd33;
        issue_read(5'd3, 1'b1, 2, 3, lat, held);
        checks++; if (lat !== 6) begin errors++; $display("FAIL drop_rd_latency got %0d want 6", lat); end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL drop_rd_req_held got %0d want 1", held); end
        ram[8] = 7'd58;
        issue_read(5'd8, 1'b1, 3, 4, lat, held);
        checks++; if (lat !== 7) begin errors++; $display("FAIL drop_wt_latency got %0d want 7", lat); end
        checks++; if (score_out !== 7'd58 || D10 !== 4'd5 || D1 !== 4'd8) begin errors++; $display("FAIL drop_wt_result got %0d %0d%0d want 58 58", score_out, D10, D1); end
    endtask

    task automatic test_busy_ignore;
        int lat = -1;
        int extra = 0;
        ram[4] = 7'd120;
        ram[2] = 7'd70;
        @(negedge clk);
        ram_gnt = 1'b1;
        read_request = 1'b1;
        playerID = 5'd4;
        @(negedge clk);
        playerID = 5'd2;
        @(negedge clk);
        read_request = 1'b0;
        for (int k = 2; k <= 20; k++) begin
            if (valid === 1'b1) begin lat = k; break; end
            @(negedge clk);
        end
        checks++; if (lat !== 4) begin errors++; $display("FAIL busy_latency got %0d want 4", lat); end
        checks++; if (score_out !== 7'd120) begin errors++; $display("FAIL busy_score got %0d want 120", score_out); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (valid === 1'b1 || busy === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL busy_queued got %0d want 0", extra); end
    endtask

    task automatic test_reset_mid;
        int lat;
        bit held;
        int stray = 0;
        @(negedge clk);
        read_request = 1'b1;
        playerID = 5'd1;
        @(negedge clk);
        read_request = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({ram_req, busy, valid} !== 3'b000) begin errors++; $display("FAIL midrst_flags got %b want 000", {ram_req, busy, valid}); end
        checks++; if (RAMaddr !== 5'd0 || score_out !== 7'd0) begin errors++; $display("FAIL midrst_data got %0d/%0d want 0/0", RAMaddr, score_out); end
        checks++; if ({D10, D1} !== 8'd0) begin errors++; $display("FAIL midrst_digits got %0d%0d want 00", D10, D1); end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (valid !== 1'b0 || busy !== 1'b0) stray++;
            @(negedge clk);
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL midrst_stray got %0d want 0", stray); end
        issue_read(5'd1, 1'b1, 0, 0, lat, held);
        checks++; if (lat !== 4 || score_out !== 7'd15) begin errors++; $display("FAIL midrst_next got lat %0d score %0d want lat 4 score 15", lat, score_out); end
    endtask

`ifdef LEADER_SCAN_EN
    task automatic test_scan;
        int lat = -1;
        int late = 0;
        for (int i = 0; i < 32; i++) ram[i] = 7'd0;
        ram[2] = 7'd70;
        ram[3] = 7'd80;
        ram[5] = 7'd80;
        @(negedge clk);
        ram_gnt = 1'b1;
        scan_request = 1'b1;
        @(negedge clk);
        scan_request = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (scan_done === 1'b1) begin lat = k; break; end
            @(negedge clk);
        end
        checks++; if (lat !== NP + 3) begin errors++; $display("FAIL scan_latency got %0d want %0d", lat, NP + 3); end
        checks++; if (top_player !== 5'd3 || top_score !== 7'd80) begin errors++; $display("FAIL scan_result got %0d/%0d want 3/80", top_player, top_score); end
        @(negedge clk);
        checks++; if ({scan_done, busy, ram_req} !== 3'b000) begin errors++; $display("FAIL scan_after got %b want 000", {scan_done, busy, ram_req}); end
        @(negedge clk);
        read_request = 1'b1;
        scan_request = 1'b1;
        playerID = 5'd5;
        @(negedge clk);
        read_request = 1'b0;
        scan_request = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (valid === 1'b1) lat = k;
            if (scan_done === 1'b1) late++;
            @(negedge clk);
        end
        checks++; if (lat !== 4 || score_out !== 7'd80) begin errors++; $display("FAIL scan_vs_read got lat %0d score %0d want lat 4 score 80", lat, score_out); end
        checks++; if (late !== 0) begin errors++; $display("FAIL scan_dropped got %0d want 0", late); end
    endtask
`else
    task automatic test_scan;
        int activity = 0;
        @(negedge clk);
        scan_request = 1'b1;
        @(negedge clk);
        scan_request = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy !== 1'b0 || ram_req !== 1'b0 || scan_done !== 1'b0) activity++;
            @(negedge clk);
        end
        checks++; if (activity !== 0) begin errors++; $display("FAIL scan_ignored got %0d want 0", activity); end
        checks++; if (top_player !== 5'd0 || top_score !== 7'd0) begin errors++; $display("FAIL scan_tied got %0d/%0d want 0/0", top_player, top_score); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 7'd0;
        rst = 1'b0;
        read_request = 1'b0;
        scan_request = 1'b0;
        playerID = 5'd0;
        ram_gnt = 1'b1;
        test_reset;
        test_read_basic;
        test_digits;
        test_addr_err;
        test_gnt_stall;
        test_gnt_drop;
        test_busy_ignore;
        test_reset_mid;
        test_scan;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
